addsub_iter: RTL and testbench

ADDSUB_ITER -- requirements
Module: addsub_iter

---
 rtl/addsub_iter.sv | 188 ++++++++++++++++++
 tb/tb_addsub_iter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/addsub_iter.sv
// addsub_iter: iterative two's-complement adder/subtractor.
//
// The operation is performed CHUNK bits per clock, least significant slice
// first, with the inter-slice carry held in a register.  After WIDTH/CHUNK
// RUN cycles the FSM spends one cycle in DONE, where the result and flags
// are valid; they then hold until the next accepted start.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request a new operation (ignored while busy)
//   A, B       WIDTH-bit two's-complement operands
//   sub        0 = A+B, 1 = A-B
//   sat        1 = saturate the result on signed overflow
//   busy       high during the RUN cycles
//   done       one-cycle pulse, result valid
//   Sum        WIDTH-bit result (saturated if requested)
//   Cout       carry out of the MSB (for subtraction 1 = no borrow)
//   V          signed overflow, before saturation
//   N          Sum[WIDTH-1]
//   Z          Sum == 0
module addsub_iter #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;        // operand A, shifted right one slice per cycle
  logic [WIDTH-1:0] b_q, b_d;        // effective operand (B or ~B), shifted likewise
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;    // raw result, slices shifted in from the top
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             z_q, z_d;

  logic [CHUNK:0]   slice_s;
  logic             load_s;
  logic             last_s;

  // Next-state, datapath and result computation.
  always_comb begin
    slice_s = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    load_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_s  = (state_q == S_RUN) && (cnt_q == LAST_CNT);

    case (state_q)
      S_IDLE:  state_d = load_s ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_s ? S_DONE : S_RUN;
      S_DONE:  state_d = load_s ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_s) begin
      // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
      a_d     = A;
      b_d     = sub ? ~B : B;
      carry_d = sub;
      res_d   = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
      a_msb_d = A[WIDTH-1];
      b_msb_d = sub ? ~B[WIDTH-1] : B[WIDTH-1];
      sat_d   = sat;
    end else if (state_q == S_RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      carry_d = slice_s[CHUNK];
      res_d   = (res_q >> CHUNK) | (WIDTH'(slice_s[CHUNK-1:0]) << (WIDTH - CHUNK));
      cnt_d   = cnt_q + CW'(1);
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      sat_d   = sat_q;
    end else begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      sat_d   = sat_q;
    end

    if (last_s) begin
      // Carry-in(MSB) ^ carry-out(MSB) equals "operands share a sign that
      // the raw result does not", which needs no access to the inner carry.
      cout_d = slice_s[CHUNK];
      v_d    = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
      if (sat_q && v_d) begin
        sum_d = a_msb_q ? SAT_NEG : SAT_POS;
      end else begin
        sum_d = res_d;
      end
      n_d = sum_d[WIDTH-1];
      z_d = (sum_d == {WIDTH{1'b0}});
    end else begin
      cout_d = cout_q;
      v_d    = v_q;
      sum_d  = sum_q;
      n_d    = n_q;
      z_d    = z_q;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Testbench for addsub_iter: a WIDTH=16/CHUNK=4 instance plus a
// WIDTH=16/CHUNK=16 instance sharing the same inputs, checked against an
// arithmetic reference model.
module tb_addsub_iter;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, sat;
  logic [15:0] a, b;
  logic        busy, done, cout, v, n, z;
  logic [15:0] sum;
  logic        busy1, done1, cout1, v1, n1, z1;
  logic [15:0] sum1;

  int checks = 0;
  int fails  = 0;

  logic [15:0] exp_sum;
  logic        exp_c, exp_v, exp_n, exp_z;

  addsub_iter #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .sub(sub), .sat(sat),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .V(v), .N(n), .Z(z)
  );

  addsub_iter #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .sub(sub), .sat(sat),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .V(v1), .N(n1), .Z(z1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb,
                       input logic ts, input logic tst);
    int unsigned u;
    int          r;
    if (ts) begin
      u = 32'(ta) + 32'(16'hFFFF ^ tb) + 32'd1;
      r = int'($signed(ta)) - int'($signed(tb));
    end else begin
      u = 32'(ta) + 32'(tb);
      r = int'($signed(ta)) + int'($signed(tb));
    end
    exp_c = u[16];
    exp_v = (r > 32767) || (r < -32768);
    if (tst && exp_v) exp_sum = ta[15] ? 16'h8000 : 16'h7FFF;
    else              exp_sum = u[15:0];
    exp_n = exp_sum[15];
    exp_z = (exp_sum == 16'h0000);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic ts, input logic tst, input bit inject);
    int busy_cnt = 0;
    int lat = 0;
    int lat1 = 0;
    model(ta, tb, ts, tst);
    a = ta; b = tb; sub = ts; sat = tst; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done1 && lat1 == 0) begin
        lat1 = i;
        chk("c16_sum", {15'd0, cout1, sum1}, {15'd0, exp_c, exp_sum});
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
      if (inject && i == 2) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = ~ts; sat = ~tst;
      end
      if (inject && i == 3) start = 1'b0;
    end
    chk("done_latency", lat, 32'd5);
    chk("busy_cycles", busy_cnt, 32'd4);
    chk("c16_latency", lat1, 32'd2);
    chk("sum", {16'd0, sum}, {16'd0, exp_sum});
    chk("flags_cvnz", {28'd0, cout, v, n, z}, {28'd0, exp_c, exp_v, exp_n, exp_z});
  endtask

  task automatic hold_check();
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sum_held", {16'd0, sum}, {16'd0, exp_sum});
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; sat = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {12'd0, busy, done, cout, v, n, z, sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("basic_sum", {16'd0, sum}, 32'h1235);
    hold_check();
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("ovf_nosat", {16'd0, sum, v, n}, {16'd0, 16'h8000, 1'b1, 1'b1});
    @(negedge clk);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("ovf_sat_pos", {16'd0, sum, v, n}, {16'd0, 16'h7FFF, 1'b1, 1'b0});
    @(negedge clk);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    chk("ovf_sat_neg", {16'd0, sum, v, cout}, {16'd0, 16'h8000, 1'b1, 1'b1});
    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("wrap_zero", {16'd0, sum, cout, z, v}, {16'd0, 16'h0000, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0);
    chk("sub_equal", {16'd0, sum, z, cout}, {16'd0, 16'h0000, 1'b1, 1'b1});
    @(negedge clk);

    // Second start two cycles into RUN must be ignored.
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    hold_check();

    // Start held high in DONE chains straight into the next operation.
    run_op(16'h4000, 16'h4000, 1'b0, 1'b1, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0);
    hold_check();

    // Reset in the third RUN cycle aborts the operation.
    a = 16'h2468; b = 16'h1357; sub = 1'b0; sat = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_run_reset", {12'd0, busy, done, cout, v, n, z, sum}, 32'd0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, seen_done}, 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("reset_priority", {30'd0, busy, done}, 32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h2468, 16'h1357, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 4 == 0) begin
        ra[15] = 1'b0; ra[14] = 1'b1; rb[15] = ra[15] ^ k[2]; rb[14] = 1'b1;
      end
      run_op(ra, rb, 1'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
